// File: rtl/reg16_sclr_pkg.sv
// reg16_sclr_pkg: shared width/reset defaults and data type for the multiplier datapath
package reg16_sclr_pkg;
  localparam int DEF_WIDTH = 16;
  localparam logic [DEF_WIDTH-1:0] DEF_RESET_VALUE = '0;
  typedef logic [DEF_WIDTH-1:0] data_t;
endpackage

// File: rtl/reg16_sclr.sv
// reg16_sclr: enabled parallel-load register with sync active-low clear; REG16_SCLR_LOAD_FLAG_EN adds load_flag
module reg16_sclr
  import reg16_sclr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEF_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] datain,
  input  logic             clk_ena,
  input  logic             sclr_n,
  output logic [WIDTH-1:0] reg_out
`ifdef REG16_SCLR_LOAD_FLAG_EN
  ,
  output logic             load_flag
`endif
);
  // clear wins over load; both only on enabled edges, clear value is always zero
  always_ff @(posedge clk or posedge rst)
    if (rst) reg_out <= RESET_VALUE;
    else if (clk_ena) reg_out <= sclr_n ? datain : '0;
`ifdef REG16_SCLR_LOAD_FLAG_EN
  // one-cycle pulse after any enabled edge, load or clear
  always_ff @(posedge clk or posedge rst)
    if (rst) load_flag <= 1'b0;
    else load_flag <= clk_ena;
`endif
  // control inputs must be known whenever the register can update
  a_ctrl_known: assert property (@(posedge clk) disable iff (rst) !$isunknown({clk_ena, sclr_n}))
    else $error("reg16_sclr: X/Z on clk_ena or sclr_n");
endmodule

// File: tb/tb_reg16_sclr.sv
// tb_reg16_sclr: randomized self-checking bench for reg16_sclr against a behavioural model
module tb_reg16_sclr;
  localparam int W = 16;
  localparam logic [W-1:0] RV = 16'hBEEF;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [W-1:0] datain = '0;
  logic clk_ena = 1'b0;
  logic sclr_n = 1'b1;
  logic [W-1:0] reg_out;
  logic load_flag;
  int total = 0;
  int passed = 0;
  logic [W-1:0] exp_q;
  logic exp_f;
  always #5 clk = ~clk;
  reg16_sclr #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk(clk),
    .rst(rst),
    .datain(datain),
    .clk_ena(clk_ena),
    .sclr_n(sclr_n),
    .reg_out(reg_out)
`ifdef REG16_SCLR_LOAD_FLAG_EN
    ,
    .load_flag(load_flag)
`endif
  );
`ifndef REG16_SCLR_LOAD_FLAG_EN
  assign load_flag = 1'b0;
`endif
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    else passed++;
  endtask
  task automatic chk_all(input string tag);
    chk(tag, reg_out, exp_q);
`ifdef REG16_SCLR_LOAD_FLAG_EN
    chk({tag, "_flag"}, {15'd0, load_flag}, {15'd0, exp_f});
`endif
  endtask
  task automatic step(input logic e, input logic s, input logic [W-1:0] d);
    @(negedge clk);
    clk_ena = e;
    sclr_n = s;
    datain = d;
    #1 chk("pre_edge_hold", reg_out, exp_q);
    @(posedge clk);
    #1;
    if (e) exp_q = s ? d : '0;
    exp_f = e;
    chk_all("post_edge");
  endtask
  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q = RV;
    exp_f = 1'b0;
    #1 chk_all("async_rst");
    #1 rst = 1'b0;
  endtask
  initial begin
    exp_q = RV;
    exp_f = 1'b0;
    clk_ena = 1'b0;
    sclr_n = 1'b0;
    datain = 16'd1000;
    #1 rst = 1'b1;
    #1 chk_all("reset_t0");
    repeat (3) begin
      @(posedge clk);
      #1 chk_all("reset_hold");
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 16'd1000);
    step(1'b0, 1'b1, 16'd1000);
    step(1'b1, 1'b1, 16'd1000);
    chk("load_1000", reg_out, 16'd1000);
    step(1'b0, 1'b0, 16'd1000);
    chk("hold_clr_dis", reg_out, 16'd1000);
    step(1'b1, 1'b0, 16'd1000);
    chk("clear", reg_out, 16'd0);
    step(1'b1, 1'b1, 16'd20);
    chk("load_20", reg_out, 16'd20);
    step(1'b1, 1'b0, 16'd1);
    chk("clr_beats_load", reg_out, 16'd0);
    step(1'b1, 1'b1, 16'hFFFF);
    async_reset();
    chk("rst_mid_cycle", reg_out, RV);
    step(1'b1, 1'b1, 16'h1234);
    chk("load_after_rst", reg_out, 16'h1234);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) async_reset();
      else step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0), W'($urandom));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/reg16_sclr.md
Name: reg16_sclr

Overview:
- 16-bit parallel-load register with clock enable and synchronous active-low clear.
- Used as the product/operand holding register in the sequential multiplier datapath.
- Loads `datain` on an enabled clock edge.
- Clears to zero on an enabled clock edge when `sclr_n` is low.
- Asynchronous active-high reset forces the power-up value.

Parameters:
- WIDTH, 16, data width of `datain` and `reg_out`.
- RESET_VALUE, 0, value driven onto `reg_out` by asynchronous reset; WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- datain  input  WIDTH  parallel load data.
- clk_ena  input  1  clock enable; when 0 the register holds.
- sclr_n  input  1  synchronous clear, active-low, qualified by `clk_ena`.
- reg_out  output  WIDTH  registered contents.

Behaviour:
- Single clock domain, one clock: `clk`. Reset is asynchronous and active-high: `rst`.
- `rst`=1: `reg_out` = RESET_VALUE immediately, independent of `clk`. It holds RESET_VALUE while `rst` is asserted.
- Deassertion of `rst` is asynchronous to the register. The first update occurs at the first rising `clk` edge with `rst`=0.
- Priority at each rising edge of `clk` (with `rst`=0):
  - `clk_ena`=0: hold `reg_out`; `sclr_n` and `datain` are ignored.
  - `clk_ena`=1 and `sclr_n`=0: `reg_out` <= 0 (all WIDTH bits).
  - `clk_ena`=1 and `sclr_n`=1: `reg_out` <= `datain`.
- Latency is one clock: an input sampled at edge N is visible on `reg_out` after edge N.
- `reg_out` is a pure register output with no combinational path from any input.
- The clear value is always 0, not RESET_VALUE.
- No arithmetic and no width conversion; `datain` is stored bit-exact.
- Glitches on `clk_ena`, `sclr_n` or `datain` between edges have no effect.
- X/Z on `clk_ena` or `sclr_n` is not a legal operating condition. Assertions flag it in simulation (see Test Plan).

Optional Feature:
- Macro: REG16_SCLR_LOAD_FLAG_EN.
- Defined: adds output port `load_flag` (1 bit, registered).
  - `load_flag` = 1 for exactly one cycle after any enabled edge: a load or a clear.
  - Otherwise `load_flag` = 0.
  - `load_flag` resets to 0 on `rst`.
- Undefined: the port and its flop do not exist; the remaining behaviour is identical.

Decomposition:
- Shared package `reg16_sclr_pkg` holds:
  - the default WIDTH constant (16);
  - the default RESET_VALUE constant;
  - a WIDTH-bit data typedef used by the multiplier datapath.
- No sub-module. The register and the optional flag flop live in one always block each.

Test Plan:
- Reset with `rst`=1, `sclr_n`=0, `clk_ena`=0, `datain`=1000 -> `reg_out`=0 throughout, with no X at time 0.
- `rst`=0, `clk_ena`=0, `sclr_n`=1, `datain`=1000 for 2 edges -> `reg_out` stays 0 (hold).
- `clk_ena`=1, `sclr_n`=1, `datain`=1000 -> `reg_out`=1000 after the next rising edge, not before.
- `reg_out`=1000, `clk_ena`=1, `sclr_n`=0 -> `reg_out`=0 after the next edge.
  - Repeat with `clk_ena`=0 -> `reg_out` stays 1000.
- Load `datain`=20, then `datain`=1 with `sclr_n`=0 in the same cycle -> 20, then 0 (clear beats load).
  - With REG16_SCLR_LOAD_FLAG_EN defined, `load_flag` pulses once per enabled edge.
- Assert `rst` mid-cycle while `reg_out`=0xFFFF -> `reg_out`=RESET_VALUE before the next edge.
  - With `clk_ena`=1, it loads again on the first edge after release.
